// File: rtl/xarb_rr.sv
// xarb_rr: registered one-hot arbiter, round-robin or fixed priority,
// optionally holding the grant until the last beat of a packet.
module xarb_rr #(
   parameter  int NREQ = 8,
   parameter  int RR   = 1,
   parameter  int HOLD = 1,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] last,
   input  logic            gnt_rdy,
   output logic [NREQ-1:0] gnt,
   output logic            gnt_vld,
   output logic [IDW-1:0]  gnt_id
);

   // state | meaning
   // IDLE  | no grant outstanding; arbitrate whenever any req is set
   // BUSY  | gnt holds one requestor until release
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t          r_state, w_state_nxt;
   logic [NREQ-1:0] r_gnt, w_gnt_nxt;
   logic [IDW-1:0]  r_gnt_id, w_gnt_id_nxt;
   logic [IDW-1:0]  r_ptr, w_ptr_eff;
   logic            w_release, w_arb;
   logic [NREQ-1:0] w_mask, w_masked, w_cand, w_win;
   logic [IDW-1:0]  w_win_id;

   // Isolate the lowest set bit: inclusive prefix OR in log2 stages, then
   // keep only the bit whose lower neighbours are all clear.
   function automatic logic [NREQ-1:0] lsb_iso(input logic [NREQ-1:0] v);
      logic [NREQ-1:0] p;
      p = v;
      for (int s = 1; s < NREQ; s = s * 2) p = p | (p << s);
      return v & ~(p << 1);
   endfunction

   assign w_release = (r_state == BUSY) && gnt_rdy && ((HOLD == 0) || (|(last & r_gnt)));
   assign w_arb     = (r_state == IDLE) || w_release;

   // The requestor being released this cycle already counts as the last one served.
   assign w_ptr_eff = w_release ? r_gnt_id : r_ptr;

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NREQ; i++) w_mask[i] = (i > int'(w_ptr_eff));
   end

   assign w_masked = req & w_mask;
   assign w_cand   = ((RR != 0) && (|w_masked)) ? w_masked : req;
   assign w_win    = lsb_iso(w_cand);

   always_comb begin
      w_win_id = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_win[i]) w_win_id = w_win_id | IDW'(i);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_gnt_id_nxt = r_gnt_id;
      if (w_arb) begin
         if (|req) begin
            w_state_nxt  = BUSY;
            w_gnt_nxt    = w_win;
            w_gnt_id_nxt = w_win_id;
         end else begin
            w_state_nxt  = IDLE;
            w_gnt_nxt    = '0;
            w_gnt_id_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_ptr    <= IDW'(NREQ - 1);
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_gnt_id <= w_gnt_id_nxt;
         r_ptr    <= w_ptr_eff;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_vld = (r_state == BUSY);
   assign gnt_id  = r_gnt_id;

endmodule

// File: tb/tb_xarb_rr.sv
// Bench for xarb_rr: three 4-requestor configurations share one stimulus
// stream and are checked every cycle against a rotating-search model.
module tb_xarb_rr;
   localparam int N = 4;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic [N-1:0] req     = '0;
   logic [N-1:0] last    = '0;
   logic         gnt_rdy = 1'b0;

   logic [N-1:0] gnt_o [3];
   logic         vld_o [3];
   logic [1:0]   id_o  [3];

   int n_cmp = 0;
   int n_bad = 0;

   int m_cur [3] = '{-1, -1, -1};
   int m_ptr [3] = '{N-1, N-1, N-1};
   bit m_rel;
   int m_win, m_j;
   logic [N-1:0] e_gnt;
   logic [1:0]   e_id;
   logic         e_vld;

   // instance 0: RR hold-off, 1: RR with packet hold, 2: fixed priority hold-off
   function automatic bit cfg_rr(input int i);
      return i != 2;
   endfunction
   function automatic bit cfg_hold(input int i);
      return i == 1;
   endfunction

   always #5 clk = ~clk;

   xarb_rr #(.NREQ(N), .RR(1), .HOLD(0)) u_h0 (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .gnt_rdy(gnt_rdy),
      .gnt(gnt_o[0]), .gnt_vld(vld_o[0]), .gnt_id(id_o[0]));
   xarb_rr #(.NREQ(N), .RR(1), .HOLD(1)) u_h1 (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .gnt_rdy(gnt_rdy),
      .gnt(gnt_o[1]), .gnt_vld(vld_o[1]), .gnt_id(id_o[1]));
   xarb_rr #(.NREQ(N), .RR(0), .HOLD(0)) u_fp (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .gnt_rdy(gnt_rdy),
      .gnt(gnt_o[2]), .gnt_vld(vld_o[2]), .gnt_id(id_o[2]));

   // Model: the holder keeps the grant until released; arbitration searches
   // upward from one past the last served index (or from 0 for fixed priority).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m_cur[i] = -1;
            m_ptr[i] = N - 1;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            m_rel = (m_cur[i] >= 0) && gnt_rdy && (!cfg_hold(i) || last[m_cur[i]]);
            if (m_cur[i] < 0 || m_rel) begin
               if (m_rel) m_ptr[i] = m_cur[i];
               m_win = -1;
               for (int k = 1; k <= N; k++) begin
                  m_j = cfg_rr(i) ? (m_ptr[i] + k) % N : k - 1;
                  if (m_win < 0 && req[m_j]) m_win = m_j;
               end
               m_cur[i] = m_win;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (m_cur[i] >= 0) begin
            e_gnt = N'(1) << m_cur[i];
            e_id  = 2'(m_cur[i]);
            e_vld = 1'b1;
         end else begin
            e_gnt = '0;
            e_id  = '0;
            e_vld = 1'b0;
         end
         n_cmp++;
         if (gnt_o[i] !== e_gnt || vld_o[i] !== e_vld || id_o[i] !== e_id) begin
            n_bad++;
            $display("FAIL model_cycle inst%0d t=%0t: got gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                     i, $time, gnt_o[i], vld_o[i], id_o[i], e_gnt, e_vld, e_id);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req = '0; last = '0; gnt_rdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // round-robin rotation with every requestor active
      do_reset();
      req = 4'b1111; gnt_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rr_rotate_id", id_o[0], k % 4);
         chk("rr_rotate_vld", vld_o[0], 1);
      end

      // packet hold: three beats of index 0, then index 2 with no bubble
      do_reset();
      req = 4'b0101; gnt_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_beat_gnt", gnt_o[1], 4'b0001);
      end
      last = 4'b0001;
      @(negedge clk);
      chk("hold_next_gnt", gnt_o[1], 4'b0100);
      chk("hold_next_vld", vld_o[1], 1);
      last = '0;

      // fixed priority starves index 3
      do_reset();
      req = 4'b1010; gnt_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("fixed_id", id_o[2], 1);
      end

      // stall with the granted request dropped
      do_reset();
      req = 4'b0010; gnt_rdy = 1'b1;
      @(negedge clk);
      chk("stall_first_gnt", gnt_o[1], 4'b0010);
      gnt_rdy = 1'b0; req = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_hold_gnt", gnt_o[1], 4'b0010);
         chk("stall_hold_h0", gnt_o[0], 4'b0010);
      end
      gnt_rdy = 1'b1; last = 4'b0010;
      @(negedge clk);
      chk("stall_release_gnt", gnt_o[1], 4'b1000);
      last = '0;

      // asynchronous reset mid-packet
      do_reset();
      req = 4'b0100; gnt_rdy = 1'b1;
      @(negedge clk);
      chk("rst_pre_gnt", gnt_o[1], 4'b0100);
      #2;
      rst_n = 1'b0; req = 4'b1100;
      #1;
      chk("rst_async_gnt", gnt_o[1], 0);
      chk("rst_async_vld", vld_o[1], 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_post_gnt", gnt_o[1], 4'b0100);

      // single request pulse
      do_reset();
      req = 4'b0001; gnt_rdy = 1'b1;
      @(negedge clk);
      chk("pulse_gnt", gnt_o[0], 4'b0001);
      req = '0;
      @(negedge clk);
      chk("pulse_idle_gnt", gnt_o[0], 0);
      chk("pulse_idle_vld", vld_o[0], 0);

      // mixed traffic, checked by the per-cycle model only
      do_reset();
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         req     = 4'($urandom_range(0, 15));
         last    = 4'($urandom_range(0, 15));
         gnt_rdy = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
